// File: rtl/gate_identifier.sv
// -----------------------------------------------------------------------------
// gate_identifier
//
// Identifies an unknown two-input combinational gate. A sweep drives the four
// input combinations {x,y} = 00, 01, 10, 11 onto the gate under observation.
// Each combination is held for SETTLE+1 cycles, and the gate response is
// sampled at the end of each hold. When the sweep completes, the captured
// truth table is registered and decoded into a gate code.
//
// Parameters
//   SETTLE   extra hold cycles per combination (1..15)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a sweep (accepted only in IDLE)
//   abort    in   synchronous cancel of a sweep in progress
//   resp     in   output of the gate under observation
//   x, y     out  stimulus to the gate (0 outside DRIVE)
//   busy     out  high while a sweep is in progress
//   done     out  single-cycle pulse on sweep completion
//   truth    out  captured truth table, bit i = resp for {x,y} = i
//   gate_id  out  decoded gate code (7 = unknown)
//   valid    out  truth matched a known gate
// -----------------------------------------------------------------------------
module gate_identifier #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       resp,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic [2:0] gate_id,
    output logic       valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
    localparam logic [2:0] ID_NONE   = 3'd7;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] truth_q, truth_d;
    logic [2:0] id_q, id_d;
    logic       valid_q, valid_d;

    logic       sample;
    logic [3:0] captured;

    // Map a complete truth table onto the known gate codes.
    function automatic logic [2:0] decode_gate(input logic [3:0] t);
        case (t)
            4'b1110: decode_gate = 3'd0;  // OR
            4'b1000: decode_gate = 3'd1;  // AND
            4'b0001: decode_gate = 3'd2;  // NOR
            4'b0111: decode_gate = 3'd3;  // NAND
            4'b0110: decode_gate = 3'd4;  // XOR
            4'b1001: decode_gate = 3'd5;  // XNOR
            4'b0011: decode_gate = 3'd6;  // NOT x
            default: decode_gate = ID_NONE;
        endcase
    endfunction

    // Last cycle of the current hold: resp is captured on the closing edge.
    assign sample = (state_q == DRIVE) && (cnt_q == SETTLE_C);

    // Shadow bits with the current response merged in at the current index,
    // so the final registration sees all four bits in the same cycle.
    always_comb begin
        captured         = shadow_q;
        captured[idx_q]  = resp;
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves it unassigned and infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        truth_d  = truth_q;
        id_d     = id_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                // abort on the same edge blocks acceptance
                if (start && !abort) begin
                    state_d  = DRIVE;
                    idx_d    = 2'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 4'd0;
                end
            end

            DRIVE: begin
                // abort wins over a coincident sample edge: nothing registers
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = 2'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 4'd0;
                end else if (sample) begin
                    shadow_d = captured;
                    cnt_d    = 4'd0;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                        truth_d = captured;
                        id_d    = decode_gate(captured);
                        valid_d = (decode_gate(captured) != ID_NONE);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 4'd0;
            truth_q  <= 4'd0;
            id_q     <= ID_NONE;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            truth_q  <= truth_d;
            id_q     <= id_d;
            valid_q  <= valid_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them
    // without waiting for a clock edge.
    assign busy    = (state_q == DRIVE);
    assign done    = (state_q == DONE);
    assign x       = busy & idx_q[1];
    assign y       = busy & idx_q[0];
    assign truth   = truth_q;
    assign gate_id = id_q;
    assign valid   = valid_q;

endmodule
